tmds_soft_serializer: RTL and testbench

Fabric-only, parametrised TMDS serializer running entirely on the bit-rate clock. It accepts one parallel word per channel through a valid/ready handshake and shifts the words out 1 or 2 bits per clock; the 2-bit mode feeds ODDR primitives downstream.
It adds an HDMI clock-channel pattern generator aligned to the data words. When the source does not supply a word in time, it inserts an idle control token and counts the underflow.
It sits between the TMDS encoders and the output buffers, and is the successor of the OSERDES-based PHY for devices or pins without OSERDES.

---
 rtl/tmds_soft_serializer.sv | 129 ++++++++++++
 tb/tb_tmds_soft_serializer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tmds_soft_serializer.sv
// Fabric-only TMDS serializer on the bit-rate clock: one word per channel per SLOTS cycles,
// shifted out 1 or 2 bits per clock, with an aligned clock-lane pattern and idle-token underflow fill.
module tmds_soft_serializer #(
   parameter int                CHANNELS     = 3,
   parameter int                WORD_W       = 10,
   parameter int                BITS_PER_CLK = 1,
   parameter bit                LSB_FIRST    = 1'b1,
   parameter logic [WORD_W-1:0] IDLE_WORD    = 10'b1101010100,
   parameter int                CNT_W        = 16
) (
   input  logic                             tmds_clk_i,
   input  logic                             rst_i,
   input  logic [CHANNELS*WORD_W-1:0]       data_i,
   input  logic                             valid_i,
   output logic                             ready_o,
   output logic [CHANNELS*BITS_PER_CLK-1:0] serial_o,
   output logic [BITS_PER_CLK-1:0]          clk_pattern_o,
   output logic                             word_strobe_o,
   output logic                             underflow_o,
   output logic [CNT_W-1:0]                 underflow_cnt_o,
   input  logic                             clear_cnt_i
);

   localparam int                SLOTS    = WORD_W / BITS_PER_CLK;
   localparam int                PH_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [PH_W-1:0]   LAST_PH  = PH_W'(SLOTS - 1);
   localparam logic [WORD_W-1:0] CLK_WORD = {{(WORD_W/2){1'b1}}, {(WORD_W/2){1'b0}}};

   logic [PH_W-1:0]            phase_q, phase_d;
   logic                       ready_q, ready_d;
   logic [CHANNELS*WORD_W-1:0] sr_q, sr_d;
   logic [WORD_W-1:0]          clk_sr_q, clk_sr_d;
   logic                       strobe_q, strobe_d;
   logic                       uflow_q, uflow_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       load_s;

   function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w);
      if (LSB_FIRST) begin
         return w >> BITS_PER_CLK;
      end else begin
         return w << BITS_PER_CLK;
      end
   endfunction

   // Earliest bit of the current slot always lands on index 0 of the output slice.
   function automatic logic [BITS_PER_CLK-1:0] slot_bits(input logic [WORD_W-1:0] w);
      logic [BITS_PER_CLK-1:0] b;
      for (int j = 0; j < BITS_PER_CLK; j++) begin
         if (LSB_FIRST) begin
            b[j] = w[j];
         end else begin
            b[j] = w[WORD_W-1-j];
         end
      end
      return b;
   endfunction

   // Next-state: phase counter, word load or shift, strobes and saturating underflow counter.
   always_comb begin
      load_s   = (phase_q == LAST_PH);
      phase_d  = phase_q;
      sr_d     = sr_q;
      clk_sr_d = clk_sr_q;
      cnt_d    = cnt_q;

      if (load_s) begin
         phase_d  = '0;
         clk_sr_d = CLK_WORD;
      end else begin
         phase_d  = phase_q + PH_W'(1);
         clk_sr_d = shift_word(clk_sr_q);
      end

      for (int c = 0; c < CHANNELS; c++) begin
         if (!load_s) begin
            sr_d[c*WORD_W +: WORD_W] = shift_word(sr_q[c*WORD_W +: WORD_W]);
         end else if (valid_i) begin
            sr_d[c*WORD_W +: WORD_W] = data_i[c*WORD_W +: WORD_W];
         end else begin
            sr_d[c*WORD_W +: WORD_W] = IDLE_WORD;
         end
      end

      ready_d  = (phase_d == LAST_PH);
      strobe_d = load_s;
      uflow_d  = load_s & ~valid_i;

      if (clear_cnt_i) begin
         cnt_d = '0;
      end else if (uflow_d && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers; phase resets to the last slot so the first edge after reset is a load edge.
   always_ff @(posedge tmds_clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q  <= LAST_PH;
         ready_q  <= 1'b1;
         sr_q     <= '0;
         clk_sr_q <= '0;
         strobe_q <= 1'b0;
         uflow_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         phase_q  <= phase_d;
         ready_q  <= ready_d;
         sr_q     <= sr_d;
         clk_sr_q <= clk_sr_d;
         strobe_q <= strobe_d;
         uflow_q  <= uflow_d;
         cnt_q    <= cnt_d;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign serial_o[c*BITS_PER_CLK +: BITS_PER_CLK] = slot_bits(sr_q[c*WORD_W +: WORD_W]);
   end

   assign clk_pattern_o   = slot_bits(clk_sr_q);
   assign ready_o         = ready_q;
   assign word_strobe_o   = strobe_q;
   assign underflow_o     = uflow_q;
   assign underflow_cnt_o = cnt_q;

endmodule

// File: tb/tb_tmds_soft_serializer.sv
// Directed bench for tmds_soft_serializer: SDR LSB/MSB-first, DDR, underflow fill,
// counter saturation/clear and mid-word reset, using four parameter variants on one clock.
module tb_tmds_soft_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] data;
   logic        valid0, valid_a, valid3, clear0, clear3;

   logic       rdy0, rdy1, rdy2, rdy3;
   logic [2:0] ser0, ser1, ser3;
   logic [5:0] ser2;
   logic       cp0, cp1, cp3;
   logic [1:0] cp2;
   logic       ws0, ws1, ws2, ws3;
   logic       uf0, uf1, uf2, uf3;
   logic [15:0] cnt0, cnt1, cnt2;
   logic [1:0]  cnt3;

   int n_assert = 0;
   int n_fail   = 0;

   logic       lsb_seq  [10] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
   logic       msb_seq  [10] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
   logic       idle_seq [10] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
   logic       clk_seq  [10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1};
   logic [1:0] ddr_seq  [5]  = '{2'b11,2'b10,2'b10,2'b10,2'b10};
   logic [1:0] ddr_clk  [5]  = '{2'b00,2'b00,2'b10,2'b11,2'b11};

   always #5 clk = ~clk;

   tmds_soft_serializer u0 (
      .tmds_clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid0), .ready_o(rdy0),
      .serial_o(ser0), .clk_pattern_o(cp0), .word_strobe_o(ws0), .underflow_o(uf0),
      .underflow_cnt_o(cnt0), .clear_cnt_i(clear0));

   tmds_soft_serializer #(.LSB_FIRST(1'b0)) u1 (
      .tmds_clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid_a), .ready_o(rdy1),
      .serial_o(ser1), .clk_pattern_o(cp1), .word_strobe_o(ws1), .underflow_o(uf1),
      .underflow_cnt_o(cnt1), .clear_cnt_i(clear0));

   tmds_soft_serializer #(.BITS_PER_CLK(2)) u2 (
      .tmds_clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid_a), .ready_o(rdy2),
      .serial_o(ser2), .clk_pattern_o(cp2), .word_strobe_o(ws2), .underflow_o(uf2),
      .underflow_cnt_o(cnt2), .clear_cnt_i(clear0));

   tmds_soft_serializer #(.CNT_W(2)) u3 (
      .tmds_clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid3), .ready_o(rdy3),
      .serial_o(ser3), .clk_pattern_o(cp3), .word_strobe_o(ws3), .underflow_o(uf3),
      .underflow_cnt_o(cnt3), .clear_cnt_i(clear3));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, w, exp_cnt3;
      logic bit0, ibit;

      rst     = 1'b1;
      data    = {10'h000, 10'h3FF, 10'h2AB};
      valid0  = 1'b1;
      valid_a = 1'b1;
      valid3  = 1'b0;
      clear0  = 1'b0;
      clear3  = 1'b0;

      #2;
      chk("rst_serial", ser0, 3'b000);
      chk("rst_clkpat", cp0, 1'b0);
      chk("rst_strobe", ws0, 1'b0);
      chk("rst_uflow", uf0, 1'b0);
      chk("rst_cnt", cnt0, 16'h0000);
      chk("rst_ready", rdy0, 1'b1);
      chk("rst_ser_ddr", ser2, 6'b000000);

      step();
      step();
      chk("rst_hold_serial", ser0, 3'b000);
      chk("rst_hold_ready", rdy0, 1'b1);
      rst = 1'b0;

      for (int k = 0; k < 65; k++) begin
         step();
         b = k % 10;
         w = k / 10;

         bit0 = (w == 2) ? idle_seq[b] : lsb_seq[b];
         if (w == 2) begin
            chk($sformatf("u0_ser_idle_k%0d", k), ser0, {idle_seq[b], idle_seq[b], idle_seq[b]});
         end else begin
            chk($sformatf("u0_ser_k%0d", k), ser0, {1'b0, 1'b1, bit0});
         end
         chk($sformatf("u0_clk_k%0d", k), cp0, clk_seq[b]);
         chk($sformatf("u0_strobe_k%0d", k), ws0, (b == 0));
         chk($sformatf("u0_ready_k%0d", k), rdy0, (b == 9));
         chk($sformatf("u0_uflow_k%0d", k), uf0, (k == 20));
         chk($sformatf("u0_cnt_k%0d", k), cnt0, (k >= 20) ? 16'd1 : 16'd0);

         chk($sformatf("u1_ser_k%0d", k), ser1[0], msb_seq[b]);
         chk($sformatf("u1_clk_k%0d", k), cp1, clk_seq[9-b]);

         chk($sformatf("u2_ser_k%0d", k), ser2[1:0], ddr_seq[k % 5]);
         chk($sformatf("u2_clk_k%0d", k), cp2, ddr_clk[k % 5]);
         chk($sformatf("u2_ready_k%0d", k), rdy2, ((k % 5) == 4));
         chk($sformatf("u2_strobe_k%0d", k), ws2, ((k % 5) == 0));

         ibit = idle_seq[b];
         chk($sformatf("u3_ser_k%0d", k), ser3, {ibit, ibit, ibit});
         chk($sformatf("u3_uflow_k%0d", k), uf3, (b == 0));
         if (w >= 5) begin
            exp_cnt3 = w - 5;
         end else begin
            exp_cnt3 = (w + 1 > 3) ? 3 : w + 1;
         end
         chk($sformatf("u3_cnt_k%0d", k), cnt3, exp_cnt3);

         if (k == 19) valid0 = 1'b0;
         if (k == 20) valid0 = 1'b1;
         if (k == 49) clear3 = 1'b1;
         if (k == 50) clear3 = 1'b0;
      end

      // u0 is now in slot 4 of a word; reset mid-word
      chk("pre_rst_serial", ser0, 3'b010);
      rst = 1'b1;
      #1;
      chk("mid_rst_serial", ser0, 3'b000);
      chk("mid_rst_clkpat", cp0, 1'b0);
      chk("mid_rst_strobe", ws0, 1'b0);
      chk("mid_rst_ready", rdy0, 1'b1);
      chk("mid_rst_cnt", cnt0, 16'h0000);
      data = {10'h000, 10'h3FF, 10'h155};
      #2;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", rdy0, 1'b1);
      step();
      chk("post_rst_ser0", ser0, 3'b011);
      chk("post_rst_strobe0", ws0, 1'b1);
      chk("post_rst_ready0", rdy0, 1'b0);
      chk("post_rst_ddr0", ser2[1:0], 2'b01);
      step();
      chk("post_rst_ser1", ser0, 3'b010);
      chk("post_rst_strobe1", ws0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
